// File: rtl/pipe_stage_ctrl_pkg.sv
// Shared pipeline constants and stage payload types.
// Provides the reset PC, the sequential PC step, the NOP code and word, and
// the packed layouts of the IF/ID and ID/EX..MEM/WB stage registers.
package pipe_stage_ctrl_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned CODE_W    = 6;

    localparam logic [XLEN-1:0]   PKG_PC_RESET = 32'h0000_3000;
    localparam logic [XLEN-1:0]   PKG_PC_STEP  = 32'd4;
    localparam logic [CODE_W-1:0] NOP_CODE     = 6'd0;
    localparam logic [XLEN-1:0]   NOP_WORD     = 32'h0;

    // IF/ID payload: fetched word and the PC it came from
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } ifid_t;

    // ID/EX, EX/MEM, MEM/WB payload: word, decoder code, PC
    typedef struct packed {
        logic [XLEN-1:0]   instr;
        logic [CODE_W-1:0] code;
        logic [XLEN-1:0]   pc;
    } stage_t;

    localparam stage_t BUBBLE = '{instr: NOP_WORD, code: NOP_CODE, pc: NOP_WORD};

endpackage

// File: rtl/pipe_stage_ctrl_reg.sv
// Generic pipeline stage register (module pipe_reg).
// Ports: clk; i_clr synchronous clear (wins over enable); i_en load enable;
//        i_d next value; o_q registered value.
module pipe_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (i_clr) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Five-stage pipeline PC and stage-register controller.
// Inputs : clk, reset (sync, active high), stall, npc_sel, npc_target,
//          imem_instr, id_instr_code.
// Outputs: pc, IF/ID, ID/EX, EX/MEM, MEM/WB registers, stall_cnt.
// Optional feature: define PERF_CNT_EN to build the stall-cycle counter;
// otherwise stall_cnt is a constant zero.
module pipe_stage_ctrl
    import pipe_stage_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PKG_PC_RESET,
    parameter logic [31:0] PC_STEP  = PKG_PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        npc_sel,
    input  logic [31:0] npc_target,
    input  logic [31:0] imem_instr,
    input  logic [5:0]  id_instr_code,
    output logic [31:0] pc,
    output logic [31:0] IF_ID_instructure_out,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] ID_EX_instructure_out,
    output logic [5:0]  ID_EX_instr_code,
    output logic [31:0] ID_EX_pc,
    output logic [31:0] EX_MEM_instructure_out,
    output logic [5:0]  EX_MEM_instr_code,
    output logic [31:0] EX_MEM_pc,
    output logic [31:0] MEM_WB_instructure_out,
    output logic [5:0]  MEM_WB_instr_code,
    output logic [31:0] MEM_WB_pc,
    output logic [31:0] stall_cnt
);

    localparam int unsigned IFID_W  = $bits(ifid_t);
    localparam int unsigned STAGE_W = $bits(stage_t);

    logic [31:0] r_pc;
    ifid_t       w_ifid_d, w_ifid_q;
    stage_t      w_idex_d, w_idex_q, w_exmem_q, w_memwb_q;

    // PC: redirect is ignored while stalled; the stalled request is retried
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_RESET;
        end else if (!stall) begin
            r_pc <= npc_sel ? npc_target : r_pc + PC_STEP;
        end
    end

    assign w_ifid_d = '{instr: imem_instr, pc: r_pc};
    assign w_idex_d = '{instr: w_ifid_q.instr, code: id_instr_code, pc: w_ifid_q.pc};

    // IF/ID holds on stall; no flush on redirect (delay slot always runs)
    pipe_reg #(.WIDTH(IFID_W)) u_if_id (
        .clk  (clk),
        .i_clr(reset),
        .i_en (!stall),
        .i_d  (w_ifid_d),
        .o_q  (w_ifid_q)
    );

    // ID/EX: a stall clears the register, which is exactly the all-zero bubble
    pipe_reg #(.WIDTH(STAGE_W)) u_id_ex (
        .clk  (clk),
        .i_clr(reset || stall),
        .i_en (1'b1),
        .i_d  (w_idex_d),
        .o_q  (w_idex_q)
    );

    pipe_reg #(.WIDTH(STAGE_W)) u_ex_mem (
        .clk  (clk),
        .i_clr(reset),
        .i_en (1'b1),
        .i_d  (w_idex_q),
        .o_q  (w_exmem_q)
    );

    pipe_reg #(.WIDTH(STAGE_W)) u_mem_wb (
        .clk  (clk),
        .i_clr(reset),
        .i_en (1'b1),
        .i_d  (w_exmem_q),
        .o_q  (w_memwb_q)
    );

`ifdef PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    // Free-running stall-cycle counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 32'h0;
        end else if (stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'h0;
`endif

    assign pc                     = r_pc;
    assign IF_ID_instructure_out  = w_ifid_q.instr;
    assign IF_ID_pc               = w_ifid_q.pc;
    assign ID_EX_instructure_out  = w_idex_q.instr;
    assign ID_EX_instr_code       = w_idex_q.code;
    assign ID_EX_pc               = w_idex_q.pc;
    assign EX_MEM_instructure_out = w_exmem_q.instr;
    assign EX_MEM_instr_code      = w_exmem_q.code;
    assign EX_MEM_pc              = w_exmem_q.pc;
    assign MEM_WB_instructure_out = w_memwb_q.instr;
    assign MEM_WB_instr_code      = w_memwb_q.code;
    assign MEM_WB_pc              = w_memwb_q.pc;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: directed scenarios followed by
// randomized traffic against a queue-based reference model.
module tb_pipe_stage_ctrl;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  code;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset, stall, npc_sel;
    logic [31:0] npc_target, imem_instr;
    logic [5:0]  id_instr_code;
    logic [31:0] pc, IF_ID_instructure_out, IF_ID_pc;
    logic [31:0] ID_EX_instructure_out, ID_EX_pc;
    logic [31:0] EX_MEM_instructure_out, EX_MEM_pc;
    logic [31:0] MEM_WB_instructure_out, MEM_WB_pc;
    logic [5:0]  ID_EX_instr_code, EX_MEM_instr_code, MEM_WB_instr_code;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [31:0] m_pc, m_if_instr, m_if_pc, m_cnt;
    ent_t        hist[$];   // ID/EX history: [0]=current ID/EX, [1]=EX/MEM, [2]=MEM/WB

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2401_0005;
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    assign imem_instr = mem_word(pc);

    pipe_stage_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel),
        .npc_target(npc_target), .imem_instr(imem_instr), .id_instr_code(id_instr_code),
        .pc(pc),
        .IF_ID_instructure_out(IF_ID_instructure_out), .IF_ID_pc(IF_ID_pc),
        .ID_EX_instructure_out(ID_EX_instructure_out), .ID_EX_instr_code(ID_EX_instr_code),
        .ID_EX_pc(ID_EX_pc),
        .EX_MEM_instructure_out(EX_MEM_instructure_out), .EX_MEM_instr_code(EX_MEM_instr_code),
        .EX_MEM_pc(EX_MEM_pc),
        .MEM_WB_instructure_out(MEM_WB_instructure_out), .MEM_WB_instr_code(MEM_WB_instr_code),
        .MEM_WB_pc(MEM_WB_pc),
        .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic void model_reset();
        ent_t z;
        z.instr = '0; z.code = '0; z.pc = '0;
        m_pc = 32'h0000_3000; m_if_instr = '0; m_if_pc = '0; m_cnt = '0;
        hist = {z, z, z};
    endfunction

    // Advance the reference by one clock using the inputs present at the edge
    function automatic void model_step();
        ent_t nxt;
        if (reset) begin
            model_reset();
            return;
        end
        if (stall) begin
            nxt.instr = '0; nxt.code = '0; nxt.pc = '0;
`ifdef PERF_CNT_EN
            m_cnt = m_cnt + 1;
`endif
        end else begin
            nxt.instr = m_if_instr; nxt.code = id_instr_code; nxt.pc = m_if_pc;
            m_if_instr = mem_word(m_pc);
            m_if_pc    = m_pc;
            m_pc       = npc_sel ? npc_target : m_pc + 32'd4;
        end
        hist.push_front(nxt);
        void'(hist.pop_back());
    endfunction

    task automatic check_all();
        check("pc", pc, m_pc);
        check("if_instr", IF_ID_instructure_out, m_if_instr);
        check("if_pc", IF_ID_pc, m_if_pc);
        check("idex_instr", ID_EX_instructure_out, hist[0].instr);
        check("idex_code", 32'(ID_EX_instr_code), 32'(hist[0].code));
        check("idex_pc", ID_EX_pc, hist[0].pc);
        check("exmem_instr", EX_MEM_instructure_out, hist[1].instr);
        check("exmem_code", 32'(EX_MEM_instr_code), 32'(hist[1].code));
        check("exmem_pc", EX_MEM_pc, hist[1].pc);
        check("memwb_instr", MEM_WB_instructure_out, hist[2].instr);
        check("memwb_code", 32'(MEM_WB_instr_code), 32'(hist[2].code));
        check("memwb_pc", MEM_WB_pc, hist[2].pc);
        check("stall_cnt", stall_cnt, m_cnt);
    endtask

    task automatic step(input logic rst, input logic stl, input logic sel,
                        input logic [31:0] tgt, input logic [5:0] code);
        reset = rst; stall = stl; npc_sel = sel; npc_target = tgt; id_instr_code = code;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    logic [31:0] prev_idex_pc;

    initial begin
        model_reset();
        // Reset
        step(1'b1, 1'b0, 1'b0, 32'h0, 6'd0);
        step(1'b1, 1'b1, 1'b1, 32'hDEAD_0000, 6'd9);
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_if", IF_ID_instructure_out, 32'h0);
        check("rst_idex", ID_EX_instructure_out, 32'h0);
        check("rst_wb", MEM_WB_instructure_out, 32'h0);

        // Sequential fetch
        step(1'b0, 1'b0, 1'b0, 32'h0, 6'd3);
        check("seq_if_instr", IF_ID_instructure_out, 32'h2401_0005);
        check("seq_if_pc", IF_ID_pc, 32'h0000_3000);
        check("seq_pc", pc, 32'h0000_3004);
        step(1'b0, 1'b0, 1'b0, 32'h0, 6'd7);
        check("seq_if_pc2", IF_ID_pc, 32'h0000_3004);

        // Single stall
        prev_idex_pc = ID_EX_pc;
        step(1'b0, 1'b1, 1'b0, 32'h0, 6'd5);
        check("stall_pc", pc, 32'h0000_3008);
        check("stall_if_pc", IF_ID_pc, 32'h0000_3004);
        check("stall_bubble", ID_EX_instructure_out, 32'h0);
        check("stall_bubble_code", 32'(ID_EX_instr_code), 32'h0);
        check("stall_exmem_pc", EX_MEM_pc, prev_idex_pc);

        // Redirect with delay slot
        step(1'b0, 1'b0, 1'b1, 32'h0000_3100, 6'd1);
        check("redir_pc", pc, 32'h0000_3100);
        check("redir_slot_pc", IF_ID_pc, 32'h0000_3008);

        // Stall over redirect
        step(1'b0, 1'b1, 1'b1, 32'h0000_3200, 6'd2);
        check("stredir_hold", pc, 32'h0000_3100);
        step(1'b0, 1'b0, 1'b1, 32'h0000_3200, 6'd2);
        check("stredir_apply", pc, 32'h0000_3200);

        // Counter: 3 stalls, reset, 2 stalls
        step(1'b1, 1'b0, 1'b0, 32'h0, 6'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 6'd4);
`ifdef PERF_CNT_EN
        check("cnt_3", stall_cnt, 32'd3);
`else
        check("cnt_off_3", stall_cnt, 32'd0);
`endif
        step(1'b1, 1'b1, 1'b0, 32'h0, 6'd0);
        check("cnt_rst", stall_cnt, 32'd0);
        check("cnt_rst_pc", pc, 32'h0000_3000);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 6'd4);
`ifdef PERF_CNT_EN
        check("cnt_2", stall_cnt, 32'd2);
`else
        check("cnt_off_2", stall_cnt, 32'd0);
`endif
        step(1'b0, 1'b0, 1'b0, 32'h0, 6'd0);
        check("resume_if_pc", IF_ID_pc, 32'h0000_3000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 {$urandom_range(0, 16'hFFFF), 14'h0, 2'b00} ^ 32'h0000_3000 | 32'hFFFF_0000 & $urandom(),
                 6'($urandom_range(0, 63)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_ctrl.md
PIPE_STAGE_CTRL -- requirements
Module: pipe_stage_ctrl

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_3000, giving the PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 32'd4, giving the sequential PC increment.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port stall, input, 1, the stall request from the hazard unit.
REQ-006 SHALL have port npc_sel, input, 1, asserted when the branch/jump resolved in ID is taken.
REQ-007 SHALL have port npc_target, input, 32, the redirect target PC.
REQ-008 SHALL have port imem_instr, input, 32, the instruction fetched at pc.
REQ-009 SHALL have port id_instr_code, input, 6, the decoder code for IF_ID_instructure_out.
REQ-010 SHALL have port pc, output, 32, the current fetch PC.
REQ-011 SHALL have ports IF_ID_instructure_out and IF_ID_pc, output, 32 each, holding the IF/ID register.
REQ-012 SHALL have ports ID_EX_instructure_out (32), ID_EX_instr_code (6) and ID_EX_pc (32), outputs, holding the ID/EX register.
REQ-013 SHALL have ports EX_MEM_instructure_out (32), EX_MEM_instr_code (6) and EX_MEM_pc (32), outputs, holding the EX/MEM register.
REQ-014 SHALL have ports MEM_WB_instructure_out (32), MEM_WB_instr_code (6) and MEM_WB_pc (32), outputs, holding the MEM/WB register.
REQ-015 SHALL have port stall_cnt, output, 32, the stall-cycle count (see Configuration).

Function
REQ-016 SHALL, with stall=0, update pc to npc_target when npc_sel=1 and to pc+PC_STEP otherwise, with the addition performed mod 2^32.
REQ-017 SHALL, with stall=0, load IF/ID with {imem_instr, pc}; the delay slot is always executed and IF/ID is never flushed on a redirect.
REQ-018 SHALL, with stall=0, load ID/EX with {IF_ID_instructure_out, id_instr_code, IF_ID_pc}.
REQ-019 SHALL, with stall=1, hold pc and IF/ID, ignore npc_sel, and load ID/EX with a bubble {32'h0, 6'd0, 32'h0}.
REQ-020 SHALL advance EX/MEM from ID/EX and MEM/WB from EX/MEM every cycle, regardless of stall.
REQ-021 SHALL make every output a register output, with no combinational path from any input to any output.
REQ-022 SHALL, under consecutive stall cycles, keep inserting one bubble per cycle and resume normal flow the first cycle stall=0.
REQ-023 SHALL keep the ID/EX-to-WB latency of a non-bubble instruction at exactly 2 cycles.

Reset
REQ-024 SHALL, when reset=1 at a clock edge, set pc to PC_RESET and clear all pipeline registers to 0, with reset taking priority over stall and npc_sel.
REQ-025 SHALL, when reset is asserted mid-stall, drop the stalled IF/ID content, and the first fetch after reset release SHALL be at PC_RESET.
REQ-026 SHALL reset stall_cnt to 0.

Configuration
REQ-027 SHALL, with PERF_CNT_EN defined, increment stall_cnt by 1 on each non-reset edge with stall=1, wrapping from 32'hFFFF_FFFF to 0.
REQ-028 SHALL, without PERF_CNT_EN, tie stall_cnt to 32'h0 and instantiate no counter flops.

Structure
REQ-029 SHALL take PC_RESET, PC_STEP, the NOP code 6'd0 and the NOP word 32'h0 from the shared define header that is included by the hazard and decode blocks.
REQ-030 SHALL build each pipeline stage register from one sub-module, pipe_reg, which has enable and clear inputs, width as a parameter, and clear taking priority over enable.

Verification
REQ-031 SHALL check reset: after reset release, pc=32'h0000_3000 and all stage instruction/code outputs are 0.
REQ-032 SHALL check sequential fetch: imem returns 32'h2401_0005 at 0x3000 with no stall; the next cycle shows IF_ID_instructure_out=32'h2401_0005 and IF_ID_pc=0x3000, and pc=0x3004.
REQ-033 SHALL check a single stall: stall=1 for one cycle with IF/ID holding 0x3004; pc and IF/ID are unchanged, ID_EX_instructure_out=0 and ID_EX_instr_code=0, and EX/MEM takes the previous ID/EX value.
REQ-034 SHALL check a redirect with delay slot: npc_sel=1 and npc_target=0x3100 while pc=0x3008; the next cycle shows pc=0x3100 and IF_ID_pc=0x3008 (slot kept).
REQ-035 SHALL check stall over redirect: stall=1 and npc_sel=1 together; pc holds, and the redirect is applied only on the following non-stall cycle.
REQ-036 SHALL check the counter with PERF_CNT_EN: 3 stall cycles, then reset, then 2 stall cycles, gives stall_cnt 3, then 0, then 2; without the macro, stall_cnt stays 0.
